// File: rtl/oled_spi_arb.sv
// Two-requester arbiter in front of an OLED SPI byte writer, with lock bursts and WAIT timeout.
// Define OLED_ARB_RR_EN for round-robin contention; default build is fixed priority A over B.
module oled_spi_arb #(
   parameter int unsigned TIMEOUT_CYC = 4095
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_a,
   input  logic       req_b,
   input  logic       dc_a,
   input  logic       dc_b,
   input  logic [7:0] data_a,
   input  logic [7:0] data_b,
   input  logic       lock_a,
   input  logic       lock_b,
   output logic       grant_a,
   output logic       grant_b,
   output logic       ack_a,
   output logic       ack_b,
   output logic       spi_ena,
   output logic       spi_dc,
   output logic [7:0] spi_data,
   input  logic       spi_done,
   output logic       timeout_err
);

   localparam int unsigned CntW =
      ($clog2(TIMEOUT_CYC + 1) > 12) ? $clog2(TIMEOUT_CYC + 1) : 12;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StLock} state_e;

   state_e          state_q, state_d;
   logic            grant_a_q, grant_a_d, grant_b_q, grant_b_d;
   logic            ack_a_q, ack_a_d, ack_b_q, ack_b_d;
   logic            ena_q, ena_d, dc_q, dc_d, err_q, err_d;
   logic [7:0]      data_q, data_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic       own_b, own_req, own_lock, own_dc;
   logic [7:0] own_data;
   logic       any_req, win_b, to_hit;

   // The granted requester is the owner; grant_b_q alone identifies it.
   assign own_b    = grant_b_q;
   assign own_req  = own_b ? req_b : req_a;
   assign own_lock = own_b ? lock_b : lock_a;
   assign own_dc   = own_b ? dc_b : dc_a;
   assign own_data = own_b ? data_b : data_a;
   assign any_req  = req_a | req_b;
   assign to_hit   = (cnt_q + CntW'(1)) == CntW'(TIMEOUT_CYC);

`ifdef OLED_ARB_RR_EN
   logic last_b_q, last_b_d;
   assign win_b = req_b & (~req_a | ~last_b_q);
`else
   assign win_b = req_b & ~req_a;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         grant_a_q <= 1'b0;
         grant_b_q <= 1'b0;
         ack_a_q   <= 1'b0;
         ack_b_q   <= 1'b0;
         ena_q     <= 1'b0;
         dc_q      <= 1'b1;
         data_q    <= 8'h00;
         err_q     <= 1'b0;
         cnt_q     <= '0;
`ifdef OLED_ARB_RR_EN
         last_b_q  <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         grant_a_q <= grant_a_d;
         grant_b_q <= grant_b_d;
         ack_a_q   <= ack_a_d;
         ack_b_q   <= ack_b_d;
         ena_q     <= ena_d;
         dc_q      <= dc_d;
         data_q    <= data_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
`ifdef OLED_ARB_RR_EN
         last_b_q  <= last_b_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (any_req) state_d = StIssue;
         StIssue: state_d = StWait;
         StWait: begin
            if (spi_done)    state_d = own_lock ? StLock : StIdle;
            else if (to_hit) state_d = StIdle;
         end
         StLock: begin
            if (own_req)        state_d = StIssue;
            else if (!own_lock) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      grant_a_d = grant_a_q;
      grant_b_d = grant_b_q;
      ack_a_d   = 1'b0;
      ack_b_d   = 1'b0;
      ena_d     = 1'b0;
      dc_d      = dc_q;
      data_d    = data_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
`ifdef OLED_ARB_RR_EN
      last_b_d  = last_b_q;
`endif
      case (state_q)
         StIdle: begin
            grant_a_d = any_req & ~win_b;
            grant_b_d = win_b;
            if (any_req) begin
               ena_d  = 1'b1;
               dc_d   = win_b ? dc_b : dc_a;
               data_d = win_b ? data_b : data_a;
`ifdef OLED_ARB_RR_EN
               last_b_d = win_b;
`endif
            end
         end
         StIssue: cnt_d = '0;
         StWait: begin
            cnt_d = cnt_q + CntW'(1);
            // A done on the timeout edge wins: it is a normal completion.
            if (spi_done || to_hit) begin
               ack_a_d = ~own_b;
               ack_b_d = own_b;
               if (!spi_done) err_d = 1'b1;
            end
         end
         StLock: begin
            if (own_req) begin
               ena_d  = 1'b1;
               dc_d   = own_dc;
               data_d = own_data;
            end else if (!own_lock) begin
               grant_a_d = 1'b0;
               grant_b_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign grant_a     = grant_a_q;
   assign grant_b     = grant_b_q;
   assign ack_a       = ack_a_q;
   assign ack_b       = ack_b_q;
   assign spi_ena     = ena_q;
   assign spi_dc      = dc_q;
   assign spi_data    = data_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_oled_spi_arb.sv
// Bench for oled_spi_arb: vector table, hand-written corner sequences, and randomized
// traffic against a queue-level model of the arbitration rules.
module tb_oled_spi_arb;

   localparam int unsigned TO = 16;
`ifdef OLED_ARB_RR_EN
   localparam bit RrEn = 1'b1;
`else
   localparam bit RrEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_a = 1'b0, req_b = 1'b0, dc_a = 1'b0, dc_b = 1'b0;
   logic [7:0] data_a = 8'h00, data_b = 8'h00;
   logic       lock_a = 1'b0, lock_b = 1'b0, spi_done = 1'b0;
   logic       grant_a, grant_b, ack_a, ack_b, spi_ena, spi_dc, timeout_err;
   logic [7:0] spi_data;

   int n_tests = 0;
   int n_fail  = 0;

   oled_spi_arb #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a), .req_b(req_b), .dc_a(dc_a), .dc_b(dc_b),
      .data_a(data_a), .data_b(data_b), .lock_a(lock_a), .lock_b(lock_b),
      .grant_a(grant_a), .grant_b(grant_b), .ack_a(ack_a), .ack_b(ack_b),
      .spi_ena(spi_ena), .spi_dc(spi_dc), .spi_data(spi_data),
      .spi_done(spi_done), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1);
   end

   typedef struct packed {
      logic       req_a;
      logic       req_b;
      logic       dc_a;
      logic [7:0] data_a;
      logic       dc_b;
      logic [7:0] data_b;
      logic [4:0] dly;
      logic       exp_b;
      logic       exp_dc;
      logic [7:0] exp_data;
   } vec_t;

   typedef struct packed {
      logic       dc;
      logic [7:0] data;
      logic       lock;
   } byte_t;

   vec_t  vecs [6];
   byte_t qa[$], qb[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, want %b", name, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h, want 0x%02h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; lock_a = 1'b0; lock_b = 1'b0;
      dc_a = 1'b0; dc_b = 1'b0; data_a = 8'h00; data_b = 8'h00; spi_done = 1'b0;
      tick();
      chk1("rst_grant_a", grant_a, 1'b0);
      chk1("rst_grant_b", grant_b, 1'b0);
      chk1("rst_ack_a", ack_a, 1'b0);
      chk1("rst_ack_b", ack_b, 1'b0);
      chk1("rst_ena", spi_ena, 1'b0);
      chk1("rst_err", timeout_err, 1'b0);
      chk1("rst_dc", spi_dc, 1'b1);
      chk8("rst_data", spi_data, 8'h00);
      rst_n = 1'b1;
   endtask

   // Called on the spi_ena step: raise done dly cycles later, return on the ack step.
   task automatic finish_byte(input int dly);
      repeat (dly) tick();
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
   endtask

   function automatic byte_t rand_byte();
      byte_t b;
      b.dc   = 1'($urandom_range(0, 1));
      b.data = 8'($urandom);
      b.lock = ($urandom_range(0, 2) == 0);
      return b;
   endfunction

   // Arbitration rule: a lone requester wins; on contention A wins unless round-robin
   // says B is due (A was served last).
   function automatic logic pick_b(input logic pa, input logic pb, input logic last_b);
      if (!pb) return 1'b0;
      return pa ? (RrEn && !last_b) : 1'b1;
   endfunction

   task automatic drive_agents();
      req_a  = (qa.size() > 0);
      lock_a = 1'b0;
      if (qa.size() > 0) begin
         dc_a = qa[0].dc; data_a = qa[0].data; lock_a = qa[0].lock;
      end
      req_b  = (qb.size() > 0);
      lock_b = 1'b0;
      if (qb.size() > 0) begin
         dc_b = qb[0].dc; data_b = qb[0].data; lock_b = qb[0].lock;
      end
   endtask

   task automatic run_random();
      int    k, ena_k, ack_k, done_k, d, r;
      logic  own_b, to_exp, err_exp, last_b, next_b, lock_hold;
      byte_t cur;
      qa.delete();
      qb.delete();
      for (int i = 0; i < 14; i++) begin
         qa.push_back(rand_byte());
         qb.push_back(rand_byte());
      end
      do_reset();
      k = 0; done_k = -1; ack_k = -1; own_b = 1'b0; to_exp = 1'b0; err_exp = 1'b0;
      cur = '0;
      last_b = 1'b1;
      drive_agents();
      next_b = pick_b(1'b1, 1'b1, last_b);
      last_b = next_b;
      ena_k  = 1;
      while ((qa.size() + qb.size() > 0 || k <= ack_k) && k < 4000) begin
         tick();
         k++;
         if (k == ack_k && to_exp) err_exp = 1'b1;
         chk1("rnd_ena", spi_ena, k == ena_k);
         chk1("rnd_ack_a", ack_a, k == ack_k && !own_b);
         chk1("rnd_ack_b", ack_b, k == ack_k && own_b);
         chk1("rnd_err", timeout_err, err_exp);
         if (k == ena_k) begin
            own_b = next_b;
            cur   = own_b ? qb[0] : qa[0];
            chk1("rnd_grant_a", grant_a, !own_b);
            chk1("rnd_grant_b", grant_b, own_b);
            chk1("rnd_dc", spi_dc, cur.dc);
            chk8("rnd_data", spi_data, cur.data);
            r = int'($urandom_range(0, 9));
            if (r >= 8) begin
               to_exp = 1'b1; done_k = -1; ack_k = k + 1 + int'(TO);
            end else begin
               d = (r == 6) ? 15 : (r == 7) ? 14 : r;
               to_exp = 1'b0; done_k = k + 1 + d; ack_k = k + 2 + d;
            end
         end
         spi_done = (k == done_k);
         if (k == ack_k) begin
            if (own_b) cur = qb.pop_front();
            else       cur = qa.pop_front();
            lock_hold = !to_exp && cur.lock;
            drive_agents();
            if (lock_hold && ((own_b ? qb.size() : qa.size()) > 0)) begin
               next_b = own_b;
               ena_k  = k + 1;
            end else if (qa.size() + qb.size() > 0) begin
               next_b = pick_b(qa.size() > 0, qb.size() > 0, last_b);
               last_b = next_b;
               // A released lock costs one extra cycle through LOCK before arbitration.
               ena_k  = lock_hold ? k + 2 : k + 1;
            end
         end
      end
      chk1("rnd_completed", k < 4000, 1'b1);
      spi_done = 1'b0;
   endtask

   initial begin
      logic [3:0] exp_order;
      int         bad;

      vecs[0] = '{1'b1, 1'b0, 1'b0, 8'hAE, 1'b0, 8'h00, 5'd5, 1'b0, 1'b0, 8'hAE};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h5A, 5'd1, 1'b1, 1'b1, 8'h5A};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 8'hC3, 5'd2, 1'b0, 1'b1, 8'h3C};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h81, 1'b1, 8'h7E, 5'd3, RrEn, RrEn,
                  RrEn ? 8'h7E : 8'h81};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 5'd1, 1'b0, 1'b1, 8'hFF};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 5'd4, 1'b1, 1'b0, 8'h00};
      exp_order = RrEn ? 4'b1010 : 4'b0000;

      // Vector table: one byte per row from IDLE.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         req_a = vecs[i].req_a; req_b = vecs[i].req_b;
         dc_a = vecs[i].dc_a; data_a = vecs[i].data_a;
         dc_b = vecs[i].dc_b; data_b = vecs[i].data_b;
         tick();
         chk1($sformatf("vec%0d_ena", i), spi_ena, 1'b1);
         chk1($sformatf("vec%0d_grant_a", i), grant_a, !vecs[i].exp_b);
         chk1($sformatf("vec%0d_grant_b", i), grant_b, vecs[i].exp_b);
         chk1($sformatf("vec%0d_dc", i), spi_dc, vecs[i].exp_dc);
         chk8($sformatf("vec%0d_data", i), spi_data, vecs[i].exp_data);
         finish_byte(int'(vecs[i].dly));
         chk1($sformatf("vec%0d_ack_a", i), ack_a, !vecs[i].exp_b);
         chk1($sformatf("vec%0d_ack_b", i), ack_b, vecs[i].exp_b);
         chk1($sformatf("vec%0d_grant_held", i), grant_b ? vecs[i].exp_b : grant_a, 1'b1);
         req_a = 1'b0; req_b = 1'b0;
         tick();
         chk1($sformatf("vec%0d_ack_clr", i), ack_a | ack_b, 1'b0);
         chk1($sformatf("vec%0d_grant_clr", i), grant_a | grant_b, 1'b0);
      end

      // Contention: both requesting for four bytes.
      do_reset();
      req_a = 1'b1; req_b = 1'b1; dc_a = 1'b0; dc_b = 1'b1; data_a = 8'hA0; data_b = 8'hB0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk1($sformatf("cont%0d_ena", i), spi_ena, 1'b1);
         chk1($sformatf("cont%0d_grant_b", i), grant_b, exp_order[i]);
         finish_byte(1);
         data_a = data_a + 8'd1;
         data_b = data_b + 8'd1;
      end
      req_a = 1'b0;
      tick();
      chk1("cont_b_after_a", grant_b & spi_ena, 1'b1);
      finish_byte(1);
      chk1("cont_b_ack", ack_b, 1'b1);
      req_b = 1'b0;
      tick();

      // Lock burst on B while A waits.
      do_reset();
      req_b = 1'b1; lock_b = 1'b1; dc_b = 1'b0; data_b = 8'hB0;
      tick();
      chk1("lock0_grant_b", grant_b & spi_ena, 1'b1);
      chk8("lock0_data", spi_data, 8'hB0);
      req_a = 1'b1; dc_a = 1'b1; data_a = 8'h55;
      finish_byte(2);
      chk1("lock0_ack_b", ack_b, 1'b1);
      data_b = 8'h00;
      tick();
      chk1("lock1_grant_b", grant_b & spi_ena & ~grant_a, 1'b1);
      chk8("lock1_data", spi_data, 8'h00);
      finish_byte(2);
      chk1("lock1_ack_b", ack_b, 1'b1);
      data_b = 8'h10;
      tick();
      chk1("lock2_grant_b", grant_b & spi_ena & ~grant_a, 1'b1);
      chk8("lock2_data", spi_data, 8'h10);
      finish_byte(2);
      chk1("lock2_ack_b", ack_b, 1'b1);
      req_b = 1'b0; lock_b = 1'b0;
      tick();
      chk1("lock_release_ena", spi_ena, 1'b0);
      chk1("lock_release_grant", grant_a | grant_b, 1'b0);
      tick();
      chk1("lock_a_served", grant_a & spi_ena, 1'b1);
      chk8("lock_a_data", spi_data, 8'h55);
      finish_byte(1);
      chk1("lock_a_ack", ack_a, 1'b1);
      req_a = 1'b0;
      tick();

      // Done on the timeout edge completes normally, then a real timeout from LOCK.
      do_reset();
      req_a = 1'b1; lock_a = 1'b1; dc_a = 1'b0; data_a = 8'h3C;
      tick();
      chk1("tob_ena", spi_ena, 1'b1);
      finish_byte(int'(TO));
      chk1("tob_ack", ack_a, 1'b1);
      chk1("tob_no_err", timeout_err, 1'b0);
      data_a = 8'h3D;
      tick();
      chk1("to_ena", spi_ena, 1'b1);
      bad = 0;
      for (int i = 0; i < int'(TO); i++) begin
         tick();
         if (ack_a || timeout_err) bad++;
      end
      chk1("to_quiet", bad == 0, 1'b1);
      tick();
      chk1("to_ack", ack_a, 1'b1);
      chk1("to_err", timeout_err, 1'b1);
      chk1("to_grant_held", grant_a, 1'b1);
      req_a = 1'b0;
      tick();
      chk1("to_lock_ignored", grant_a, 1'b0);
      repeat (3) tick();
      chk1("to_err_sticky", timeout_err, 1'b1);
      req_a = 1'b1; lock_a = 1'b0;
      tick();
      finish_byte(1);
      chk1("to_next_ack", ack_a, 1'b1);
      chk1("to_err_still", timeout_err, 1'b1);
      req_a = 1'b0;
      tick();

      // Reset in WAIT, then a stray done.
      do_reset();
      req_a = 1'b1; dc_a = 1'b0; data_a = 8'h77;
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      chk1("rstw_ack", ack_a | ack_b, 1'b0);
      chk1("rstw_grant", grant_a | grant_b, 1'b0);
      chk8("rstw_data", spi_data, 8'h00);
      chk1("rstw_dc", spi_dc, 1'b1);
      chk1("rstw_ena", spi_ena, 1'b0);
      rst_n = 1'b1; req_a = 1'b0; spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      chk1("rstw_done_ignored", ack_a | spi_ena | grant_a, 1'b0);
      tick();
      chk1("rstw_quiet", ack_a | spi_ena | grant_a, 1'b0);

      // Reset while spi_ena is high.
      req_a = 1'b1;
      tick();
      chk1("rsti_ena_pre", spi_ena, 1'b1);
      rst_n = 1'b0; req_a = 1'b0;
      tick();
      chk1("rsti_ena", spi_ena, 1'b0);
      rst_n = 1'b1;
      tick();
      chk1("rsti_quiet", spi_ena | ack_a | grant_a, 1'b0);

      // Spurious done in IDLE and ISSUE.
      do_reset();
      spi_done = 1'b1;
      tick();
      chk1("spur_idle", ack_a | ack_b | spi_ena | grant_a | grant_b, 1'b0);
      req_a = 1'b1; data_a = 8'h12;
      tick();
      chk1("spur_issue_ena", spi_ena, 1'b1);
      tick();
      spi_done = 1'b0;
      chk1("spur_issue_ack", ack_a, 1'b0);
      tick();
      chk1("spur_wait_ack", ack_a, 1'b0);
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      chk1("spur_real_ack", ack_a, 1'b1);
      req_a = 1'b0;
      tick();

      run_random();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
